rnn_mem_responder: RTL

Memory-and-stimulus responder for the RNN datapath: the slave end of its `mce`/`msel`/`maddr`/`mdata_r`/`mdata_w` memory port and the source of its `ready`/`i_en`/`idata` input handshake. It holds the step count, both bias vectors, both weight matrices, the input-vector stream and the result buffer. A host side preloads it, launches a run, and reads results back. It sits directly beside the RNN core at the top level.

---
 rtl/rnn_mem_responder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rnn_mem_responder.sv
// Memory slave and input-vector source for the RNN core.
// Holds weights, biases, step count, input stream and result bank.
module rnn_mem_responder #(
    parameter int T_MAX = 64,
    parameter int X_AW  = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mce,
    input  logic [2:0]  msel,
    input  logic [16:0] maddr,
    input  logic [19:0] mdata_w,
    output logic [19:0] mdata_r,
    input  logic        busy,
    input  logic        i_en,
    output logic        ready,
    output logic [31:0] idata,
    input  logic        ld_en,
    input  logic [2:0]  ld_sel,
    input  logic [16:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic        start,
    input  logic [16:0] rd_addr,
    output logic [19:0] rd_data,
    output logic        done,
    output logic [16:0] wr_count,
    output logic        x_ovf
);

    localparam int RES_N  = T_MAX * 64;
    localparam int RES_AW = X_AW + 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [19:0] r_wih   [0:2047];
    logic [19:0] r_ba    [0:63];
    logic [19:0] r_whh   [0:4095];
    logic [19:0] r_bb    [0:63];
    logic [19:0] r_res   [0:RES_N-1];
    logic [31:0] r_xs    [0:T_MAX-1];
    logic [19:0] r_steps;

    logic [X_AW-1:0] r_xptr;
    logic [X_AW-1:0] w_xlast;
    logic [16:0]     r_wrcnt;
    logic            r_xovf;
    logic [19:0]     r_mdata;
    logic [19:0]     r_rdata;
    logic [19:0]     w_mrd;
    logic [19:0]     w_rrd;

    logic w_ld_ok;
    logic w_core_wr;
    logic w_core_in;
    logic w_ld_res_in;
    logic w_ld_x_in;
    logic w_rd_in;

    assign w_ld_ok     = ld_en && (r_state == S_IDLE);
    assign w_core_wr   = mce && (msel == 3'b101);
    assign w_core_in   = maddr < 17'(RES_N);
    assign w_ld_res_in = ld_addr < 17'(RES_N);
    assign w_ld_x_in   = ld_addr < 17'(T_MAX);
    assign w_rd_in     = rd_addr < 17'(RES_N);

    // Host preload of every bank except the result bank
    always_ff @(posedge clk) begin
        if (w_ld_ok) begin
            case (ld_sel)
                3'b000: if (ld_addr[16:11] == '0) r_wih[ld_addr[10:0]] <= ld_data[19:0];
                3'b001: if (ld_addr[16:6] == '0) r_ba[ld_addr[5:0]] <= ld_data[19:0];
                3'b010: if (ld_addr[16:12] == '0) r_whh[ld_addr[11:0]] <= ld_data[19:0];
                3'b011: if (ld_addr[16:6] == '0) r_bb[ld_addr[5:0]] <= ld_data[19:0];
                3'b100: r_steps <= ld_data[19:0];
                3'b110: if (w_ld_x_in) r_xs[ld_addr[X_AW-1:0]] <= ld_data;
                default: ;
            endcase
        end
    end

    // Result bank: core write takes the single write port over the host
    always_ff @(posedge clk) begin
        if (w_core_wr && w_core_in) begin
            r_res[maddr[RES_AW-1:0]] <= mdata_w;
        end else if (w_ld_ok && (ld_sel == 3'b101) && w_ld_res_in) begin
            r_res[ld_addr[RES_AW-1:0]] <= ld_data[19:0];
        end
    end

    always_comb begin
        w_mrd = '0;
        case (msel)
            3'b000: if (maddr[16:11] == '0) w_mrd = r_wih[maddr[10:0]];
            3'b001: if (maddr[16:6] == '0) w_mrd = r_ba[maddr[5:0]];
            3'b010: if (maddr[16:12] == '0) w_mrd = r_whh[maddr[11:0]];
            3'b011: if (maddr[16:6] == '0) w_mrd = r_bb[maddr[5:0]];
            3'b100: w_mrd = r_steps;
            3'b101: if (w_core_in) w_mrd = r_res[maddr[RES_AW-1:0]];
            default: ;
        endcase
    end

    always_comb begin
        w_rrd = '0;
        if (w_rd_in) w_rrd = r_res[rd_addr[RES_AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mdata <= '0;
            r_rdata <= '0;
        end else begin
            r_mdata <= w_mrd;
            r_rdata <= w_rrd;
        end
    end

    // Stream ends at the last loaded step; unset or oversize T uses the full store
    always_comb begin
        w_xlast = X_AW'(T_MAX - 1);
        if ((r_steps != '0) && (r_steps <= 20'(T_MAX))) begin
            w_xlast = r_steps[X_AW-1:0] - X_AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_xptr  <= '0;
            r_xovf  <= 1'b0;
            r_wrcnt <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_xptr  <= '0;
            r_xovf  <= 1'b0;
            r_wrcnt <= '0;
        end else begin
            if (w_core_wr) r_wrcnt <= r_wrcnt + 17'd1;
            if ((r_state == S_RUN) && i_en) begin
                if (r_xptr == w_xlast) r_xovf <= 1'b1;
                else r_xptr <= r_xptr + X_AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_ARM;
            S_ARM: begin
                ready = 1'b1;
                if (busy) w_state_nxt = S_RUN;
            end
            S_RUN: if (!busy) w_state_nxt = S_DONE;
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign idata    = r_xs[r_xptr];
    assign mdata_r  = r_mdata;
    assign rd_data  = r_rdata;
    assign wr_count = r_wrcnt;
    assign x_ovf    = r_xovf;

endmodule
